// File: rtl/fifo_level.sv
// fifo_level: parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
// Optional feature: define FIFO_FWFT_EN for first-word fall-through output (head word
// always presented on o_data); leave it undefined for a registered, 1-cycle-latency read port.
module fifo_level #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int AE_THRESH  = 1,
    parameter int AF_THRESH  = 3
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_write,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_read,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_almost_empty,
    output logic                  o_almost_full,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_LVL = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_LVL    = AE_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_LVL    = AF_THRESH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic empty;
    logic full;
    logic rd_ok;
    logic wr_ok;

    // Status is derived from the registered count, so it reflects the state after the last edge.
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_LVL);

    // A read needs data; a write needs room, or a same-cycle read that frees a slot.
    assign rd_ok = i_read & ~empty;
    assign wr_ok = i_write & (~full | rd_ok);

    // Next-state for pointers, occupancy and sticky error flags; flush overrides any transfer.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (i_clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (i_write & ~wr_ok) begin
                overflow_d = 1'b1;
            end
            if (i_read & ~rd_ok) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Control state registers, cleared asynchronously by reset.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents survive reset and flush, only the pointers are discarded.
    always_ff @(posedge i_clock) begin
        if (wr_ok & ~i_clear) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

`ifdef FIFO_FWFT_EN
    // Fall-through: the head word is shown directly, and zero while nothing is stored.
    always_comb begin
        o_data = '0;
        if (!empty) begin
            o_data = mem_q[rd_ptr_q];
        end
    end
`else
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Registered read port: load the head on an accepted read, otherwise hold; flush zeroes it.
    always_comb begin
        data_d = data_q;
        if (i_clear) begin
            data_d = '0;
        end else if (rd_ok) begin
            data_d = mem_q[rd_ptr_q];
        end
    end

    // Read data register; reset discards any word in flight.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_data = data_q;
`endif

    assign o_count        = count_q;
    assign o_empty        = empty;
    assign o_full         = full;
    assign o_almost_empty = (count_q <= AE_LVL);
    assign o_almost_full  = (count_q >= AF_LVL);
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: drives fifo_level with directed scenarios and random traffic, and compares
// every output against a queue-based reference model after each clock edge.
module tb_fifo_level;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AE    = 1;
    localparam int AF    = 3;

    logic          i_clock;
    logic          i_reset;
    logic          i_clear;
    logic          i_write;
    logic [DW-1:0] i_data;
    logic          i_read;
    logic [DW-1:0] o_data;
    logic          o_empty;
    logic          o_full;
    logic          o_almost_empty;
    logic          o_almost_full;
    logic [AW:0]   o_count;
    logic          o_overflow;
    logic          o_underflow;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state: stored words in order, sticky flags, registered read word.
    logic [DW-1:0] modelQ[$];
    logic          modelOvf;
    logic          modelUnf;
    logic [DW-1:0] modelData;

    fifo_level #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AE_THRESH (AE),
        .AF_THRESH (AF)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_clear       (i_clear),
        .i_write       (i_write),
        .i_data        (i_data),
        .i_read        (i_read),
        .o_data        (o_data),
        .o_empty       (o_empty),
        .o_full        (o_full),
        .o_almost_empty(o_almost_empty),
        .o_almost_full (o_almost_full),
        .o_count       (o_count),
        .o_overflow    (o_overflow),
        .o_underflow   (o_underflow)
    );

    // 10 ns clock.
    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    // Global time limit so the run always ends.
    initial begin
        #2ms;
        $display("[TB] FAIL timeout: got still running expected finished");
        testsFailed++;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "[TB] time limit reached");
    end

    // Single comparison point: counts, and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Reference behaviour for one clock edge, written in terms of queue occupancy.
    task automatic modelStep(input logic clr, input logic wr, input logic rd,
                             input logic [DW-1:0] d);
        int  n;
        bit  rdAcc;
        bit  wrAcc;
        if (clr) begin
            modelQ.delete();
            modelOvf  = 1'b0;
            modelUnf  = 1'b0;
            modelData = '0;
        end else begin
            n     = modelQ.size();
            rdAcc = rd && (n > 0);
            wrAcc = wr && ((n < DEPTH) || rdAcc);
            if (rdAcc) modelData = modelQ.pop_front();
            if (wrAcc) modelQ.push_back(d);
            if (wr && !wrAcc) modelOvf = 1'b1;
            if (rd && !rdAcc) modelUnf = 1'b1;
        end
    endtask

    function automatic logic [DW-1:0] expectedData();
`ifdef FIFO_FWFT_EN
        return (modelQ.size() > 0) ? modelQ[0] : '0;
`else
        return modelData;
`endif
    endfunction

    // Compare every output against the model.
    task automatic checkAll(input string tag);
        int n;
        n = modelQ.size();
        checkOutput({tag, ".count"}, 32'(o_count), 32'(n));
        checkOutput({tag, ".empty"}, 32'(o_empty), 32'(n == 0));
        checkOutput({tag, ".full"}, 32'(o_full), 32'(n == DEPTH));
        checkOutput({tag, ".aempty"}, 32'(o_almost_empty), 32'(n <= AE));
        checkOutput({tag, ".afull"}, 32'(o_almost_full), 32'(n >= AF));
        checkOutput({tag, ".ovf"}, 32'(o_overflow), 32'(modelOvf));
        checkOutput({tag, ".unf"}, 32'(o_underflow), 32'(modelUnf));
        checkOutput({tag, ".data"}, 32'(o_data), 32'(expectedData()));
    endtask

    // One clock of stimulus: drive inputs, step the model at the edge, check 1 ns later.
    task automatic applyStimulus(input string tag, input logic clr, input logic wr,
                                 input logic rd, input logic [DW-1:0] d);
        i_clear = clr;
        i_write = wr;
        i_read  = rd;
        i_data  = d;
        @(posedge i_clock);
        modelStep(clr, wr, rd, d);
        #1;
        i_clear = 1'b0;
        i_write = 1'b0;
        i_read  = 1'b0;
        checkAll(tag);
    endtask

    // Asynchronous reset pulse: outputs must clear without waiting for a clock edge.
    task automatic resetPulse(input string tag);
        i_reset = 1'b1;
        #1;
        modelQ.delete();
        modelOvf  = 1'b0;
        modelUnf  = 1'b0;
        modelData = '0;
        checkAll({tag, ".async"});
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        #1;
        checkAll({tag, ".released"});
    endtask

    initial begin
        logic [DW-1:0] s2Words [3];
        i_reset = 1'b0;
        i_clear = 1'b0;
        i_write = 1'b0;
        i_read  = 1'b0;
        i_data  = '0;
        s2Words = '{8'h81, 8'h7E, 8'h08};

        // Reset state.
        resetPulse("s1");
        checkOutput("s1.count_const", 32'(o_count), 32'd0);
        checkOutput("s1.empty_const", 32'(o_empty), 32'd1);

        // Three writes then three reads, data in order.
        for (int i = 0; i < 3; i++) applyStimulus("s2.wr", 1'b0, 1'b1, 1'b0, s2Words[i]);
        checkOutput("s2.count_const", 32'(o_count), 32'd3);
        checkOutput("s2.afull_const", 32'(o_almost_full), 32'd1);
        for (int i = 0; i < 3; i++) begin
`ifdef FIFO_FWFT_EN
            checkOutput("s2.head_const", 32'(o_data), 32'(s2Words[i]));
`endif
            applyStimulus("s2.rd", 1'b0, 1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
            checkOutput("s2.data_const", 32'(o_data), 32'(s2Words[i]));
`endif
        end
        checkOutput("s2.empty_const", 32'(o_empty), 32'd1);

        // Fill, then a rejected write.
        for (int i = 1; i <= 4; i++) applyStimulus("s3.wr", 1'b0, 1'b1, 1'b0, DW'(i));
        applyStimulus("s3.wr_full", 1'b0, 1'b1, 1'b0, 8'hAA);
        checkOutput("s3.full_const", 32'(o_full), 32'd1);
        checkOutput("s3.ovf_const", 32'(o_overflow), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus("s3.rd", 1'b0, 1'b0, 1'b1, 8'h00);

        // Full with simultaneous read and write, pointers wrap.
        applyStimulus("s4.clr", 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 4; i++) applyStimulus("s4.wr", 1'b0, 1'b1, 1'b0, DW'(i));
        for (int i = 0; i < 4; i++) begin
            applyStimulus("s4.rw", 1'b0, 1'b1, 1'b1, DW'(8'h10 + i));
            checkOutput("s4.count_const", 32'(o_count), 32'd4);
        end
        for (int i = 0; i < 4; i++) applyStimulus("s4.rd", 1'b0, 1'b0, 1'b1, 8'h00);

        // Underflow, then flush with a simultaneous write that must be ignored.
        applyStimulus("s5.rd_empty", 1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("s5.unf_const", 32'(o_underflow), 32'd1);
        applyStimulus("s5.clear", 1'b1, 1'b1, 1'b0, 8'h5A);
        checkOutput("s5.unf_cleared", 32'(o_underflow), 32'd0);
        applyStimulus("s5.idle", 1'b0, 1'b0, 1'b0, 8'h00);

        // Single word in, single word out.
        applyStimulus("s6.wr", 1'b0, 1'b1, 1'b0, 8'h55);
`ifdef FIFO_FWFT_EN
        checkOutput("s6.head_const", 32'(o_data), 32'h55);
`endif
        applyStimulus("s6.rd", 1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("s6.empty_const", 32'(o_empty), 32'd1);

        // Random traffic with occasional flushes and mid-operation resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 299) == 0) begin
                #($urandom_range(1, 6));
                resetPulse("rnd.reset");
            end else begin
                applyStimulus("rnd",
                              1'($urandom_range(0, 39) == 0),
                              1'($urandom_range(0, 99) < 55),
                              1'($urandom_range(0, 99) < 50),
                              DW'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
